// File: rtl/pc_flow_ctrl_if.sv
// Handshake bundle between the program-flow controller and the PC/IR/stack datapath.
// master = controller side, slave = datapath side.
interface pc_flow_ctrl_if;
    logic [17:0] ir;
    logic        c;
    logic        z;
    logic        int_req;
    logic [1:0]  pc_mux_sel;
    logic        pc_ld;
    logic        pc_inc;
    logic        ir_ld;
    logic        stk_push;
    logic        stk_pop;
    logic        ie;
    logic        int_ack;
    logic [5:0]  stk_depth;
    logic        stk_err;

    modport master (
        input  ir, c, z, int_req,
        output pc_mux_sel, pc_ld, pc_inc, ir_ld, stk_push, stk_pop, ie, int_ack, stk_depth,
               stk_err
    );

    modport slave (
        output ir, c, z, int_req,
        input  pc_mux_sel, pc_ld, pc_inc, ir_ld, stk_push, stk_pop, ie, int_ack, stk_depth,
               stk_err
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Program-flow controller: fetch/execute sequencing, branch/call/return decode,
// return-stack depth tracking and edge-triggered interrupt entry.
module pc_flow_ctrl #(
    parameter int unsigned STK_MAX = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_flow_ctrl_if.master    bus_io
);

    localparam logic [5:0] StkMax = 6'(STK_MAX);

    localparam logic [4:0] OpBrn   = 5'b00100;
    localparam logic [4:0] OpBreq  = 5'b00101;
    localparam logic [4:0] OpBrne  = 5'b00110;
    localparam logic [4:0] OpBrcs  = 5'b00111;
    localparam logic [4:0] OpBrcc  = 5'b01000;
    localparam logic [4:0] OpCall  = 5'b01001;
    localparam logic [4:0] OpRet   = 5'b01010;
    localparam logic [4:0] OpRetie = 5'b01011;
    localparam logic [4:0] OpSei   = 5'b01100;
    localparam logic [4:0] OpCli   = 5'b01101;

    typedef enum logic [2:0] {StRst, StInit, StFetch, StExec, StIntr, StHalt} state_e;

    state_e     state_q, state_d;
    logic       ie_q, ie_d;
    logic       pend_q, pend_d;
    logic       int_prev_q;
    logic       err_q, err_d;
    logic [5:0] depth_q, depth_d;

    logic       pend_now;
    logic       taken;
    logic [4:0] opcode;
    logic [1:0] pc_mux_sel;
    logic       pc_ld, pc_inc, ir_ld, stk_push, stk_pop, int_ack;
    logic       unused_ir;

    assign opcode    = bus_io.ir[17:13];
    assign unused_ir = ^bus_io.ir[12:0];
    assign pend_now  = pend_q | (bus_io.int_req & ~int_prev_q);

    always_comb begin
        unique case (opcode)
            OpBrn:   taken = 1'b1;
            OpBreq:  taken = bus_io.z;
            OpBrne:  taken = ~bus_io.z;
            OpBrcs:  taken = bus_io.c;
            OpBrcc:  taken = ~bus_io.c;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRst;
            ie_q       <= 1'b0;
            pend_q     <= 1'b0;
            int_prev_q <= 1'b0;
            err_q      <= 1'b0;
            depth_q    <= '0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            pend_q     <= pend_d;
            int_prev_q <= bus_io.int_req;
            err_q      <= err_d;
            depth_q    <= depth_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ie_d       = ie_q;
        err_d      = err_q;
        depth_d    = depth_q;
        pc_mux_sel = 2'b00;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        ir_ld      = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        int_ack    = 1'b0;

        unique case (state_q)
            StRst: state_d = StInit;
            StInit: begin
                pc_ld      = 1'b1;
                pc_mux_sel = 2'b11;
                ie_d       = 1'b0;
                depth_d    = '0;
                state_d    = StFetch;
            end
            StFetch: begin
                ir_ld   = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (opcode)
                    OpBrn, OpBreq, OpBrne, OpBrcs, OpBrcc: begin
                        pc_ld  = taken;
                        pc_inc = ~taken;
                    end
                    OpCall: begin
                        if (depth_q == StkMax) begin
                            err_d   = 1'b1;
                            state_d = StHalt;
                        end else begin
                            stk_push = 1'b1;
                            pc_ld    = 1'b1;
                            depth_d  = depth_q + 6'd1;
                        end
                    end
                    OpRet, OpRetie: begin
                        if (depth_q == '0) begin
                            err_d   = 1'b1;
                            state_d = StHalt;
                        end else begin
                            stk_pop    = 1'b1;
                            pc_ld      = 1'b1;
                            pc_mux_sel = 2'b01;
                            depth_d    = depth_q - 6'd1;
                            if (opcode == OpRetie) ie_d = 1'b1;
                        end
                    end
                    OpSei: begin
                        ie_d   = 1'b1;
                        pc_inc = 1'b1;
                    end
                    OpCli: begin
                        ie_d   = 1'b0;
                        pc_inc = 1'b1;
                    end
                    default: pc_inc = 1'b1;
                endcase
                // Judged on post-EXEC IE/depth so SEI with a same-cycle edge enters INTR at once.
                if (state_d == StFetch && pend_now && ie_d && depth_d < StkMax) begin
                    state_d = StIntr;
                end
            end
            StIntr: begin
                stk_push   = 1'b1;
                pc_ld      = 1'b1;
                pc_mux_sel = 2'b10;
                int_ack    = 1'b1;
                ie_d       = 1'b0;
                depth_d    = depth_q + 6'd1;
                state_d    = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase

        pend_d = (state_d == StIntr) ? 1'b0 : pend_now;
    end

    assign bus_io.pc_mux_sel = pc_mux_sel;
    assign bus_io.pc_ld      = pc_ld;
    assign bus_io.pc_inc     = pc_inc;
    assign bus_io.ir_ld      = ir_ld;
    assign bus_io.stk_push   = stk_push;
    assign bus_io.stk_pop    = stk_pop;
    assign bus_io.int_ack    = int_ack;
    assign bus_io.ie         = ie_q;
    assign bus_io.stk_depth  = depth_q;
    assign bus_io.stk_err    = err_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: branch decode table, directed corner sequences and
// randomized instruction streams checked every cycle against a queue-based model.
module tb_pc_flow_ctrl;

    localparam int unsigned StkMax = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc_flow_ctrl_if bus ();

    pc_flow_ctrl #(.STK_MAX(StkMax)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase of the instruction cycle, IE, pending, error and a return stack.
    typedef enum {MRst, MInit, MFetch, MExec, MIntr, MHalt} mphase_e;
    mphase_e m_ph;
    bit      m_ie, m_pend, m_prev, m_err;
    int      m_stk[$];

    typedef struct {
        logic [4:0] op;
        logic       c;
        logic       z;
        logic       ld;
        logic       inc;
    } bvec_t;

    function automatic logic [15:0] got_vec();
        return {bus.pc_mux_sel, bus.pc_ld, bus.pc_inc, bus.ir_ld, bus.stk_push, bus.stk_pop,
                bus.ie, bus.int_ack, bus.stk_depth, bus.stk_err};
    endfunction

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = MRst;
        m_ie = 0;
        m_pend = 0;
        m_prev = 0;
        m_err = 0;
        m_stk.delete();
    endtask

    // One clock cycle: drive at negedge, compare all outputs against the model, advance model.
    task automatic apply(input logic [4:0] op, input logic c, input logic z, input logic intr,
                         input logic rst = 1'b1);
        logic [1:0] sel;
        logic       ld, inc, irl, psh, pp, ack, tk;
        logic [15:0] exp;
        bit         cur_ie, cur_err, pn;
        logic [5:0] cur_depth;
        mphase_e    nxt;
        @(negedge clk);
        bus.ir      = {op, 13'($urandom)};
        bus.c       = c;
        bus.z       = z;
        bus.int_req = intr;
        rst_n       = rst;
        #1;
        if (!rst) begin
            model_reset();
            check16("in_reset", got_vec(), 16'h0000);
            return;
        end
        sel = 2'b00; ld = 0; inc = 0; irl = 0; psh = 0; pp = 0; ack = 0; tk = 0;
        cur_ie = m_ie; cur_err = m_err; cur_depth = 6'(m_stk.size());
        pn = m_pend || (intr && !m_prev);
        nxt = m_ph;
        case (m_ph)
            MRst: nxt = MInit;
            MInit: begin
                ld = 1; sel = 2'b11; m_ie = 0; m_stk.delete(); nxt = MFetch;
            end
            MFetch: begin
                irl = 1; nxt = MExec;
            end
            MExec: begin
                nxt = MFetch;
                if (op >= 5'd4 && op <= 5'd8) begin
                    tk = (op == 5'd4) || (op == 5'd5 && z) || (op == 5'd6 && !z) ||
                         (op == 5'd7 && c) || (op == 5'd8 && !c);
                    if (tk) ld = 1; else inc = 1;
                end else if (op == 5'd9) begin
                    if (m_stk.size() == StkMax) begin
                        m_err = 1; nxt = MHalt;
                    end else begin
                        m_stk.push_back(1); psh = 1; ld = 1;
                    end
                end else if (op == 5'd10 || op == 5'd11) begin
                    if (m_stk.size() == 0) begin
                        m_err = 1; nxt = MHalt;
                    end else begin
                        void'(m_stk.pop_back()); pp = 1; ld = 1; sel = 2'b01;
                        if (op == 5'd11) m_ie = 1;
                    end
                end else begin
                    inc = 1;
                    if (op == 5'd12) m_ie = 1;
                    if (op == 5'd13) m_ie = 0;
                end
                if (nxt == MFetch && pn && m_ie && m_stk.size() < StkMax) nxt = MIntr;
            end
            MIntr: begin
                psh = 1; ld = 1; sel = 2'b10; ack = 1; m_ie = 0; m_stk.push_back(2);
                nxt = MFetch;
            end
            default: nxt = MHalt;
        endcase
        exp = {sel, ld, inc, irl, psh, pp, cur_ie, ack, cur_depth, cur_err};
        check16(m_ph.name(), got_vec(), exp);
        m_pend = (nxt == MIntr) ? 1'b0 : pn;
        m_prev = intr;
        m_ph = nxt;
    endtask

    // Reset pulse; returns with the INIT cycle already applied.
    task automatic do_reset();
        apply(5'd0, 0, 0, 0, 1'b0);
        apply(5'd0, 0, 0, 0, 1'b0);
        apply(5'd0, 0, 0, 0, 1'b1);
        apply(5'd0, 0, 0, 0);
    endtask

    task automatic instr(input logic [4:0] op, input logic c, input logic z, input logic intr);
        apply(op, c, z, 0);
        apply(op, c, z, intr);
    endtask

    bvec_t tbl[13];
    logic [4:0] rop;

    initial begin
        tbl[0]  = '{5'd4,  0, 0, 1, 0};
        tbl[1]  = '{5'd5,  0, 1, 1, 0};
        tbl[2]  = '{5'd5,  0, 0, 0, 1};
        tbl[3]  = '{5'd6,  0, 0, 1, 0};
        tbl[4]  = '{5'd6,  0, 1, 0, 1};
        tbl[5]  = '{5'd7,  1, 0, 1, 0};
        tbl[6]  = '{5'd7,  0, 0, 0, 1};
        tbl[7]  = '{5'd8,  0, 1, 1, 0};
        tbl[8]  = '{5'd8,  1, 0, 0, 1};
        tbl[9]  = '{5'd12, 0, 0, 0, 1};
        tbl[10] = '{5'd13, 1, 1, 0, 1};
        tbl[11] = '{5'd31, 1, 0, 0, 1};
        tbl[12] = '{5'd0,  0, 1, 0, 1};

        bus.ir = '0; bus.c = 0; bus.z = 0; bus.int_req = 0;
        model_reset();
        #2;
        check16("por_outputs", got_vec(), 16'h0000);

        // Reset release -> RST, INIT, FETCH, EXEC
        apply(5'd0, 0, 0, 0, 1'b0);
        apply(5'd0, 0, 0, 0, 1'b0);
        apply(5'd0, 0, 0, 0, 1'b1);
        apply(5'd0, 0, 0, 0);
        check1("init_pc_ld", bus.pc_ld, 1'b1);
        check1("init_sel11", bus.pc_mux_sel == 2'b11, 1'b1);
        apply(5'd0, 0, 0, 0);
        check1("fetch_ir_ld", bus.ir_ld, 1'b1);
        check1("fetch_no_other", bus.pc_ld | bus.pc_inc | bus.stk_push | bus.stk_pop, 1'b0);
        apply(5'd0, 0, 0, 0);
        check1("exec_seq_inc", bus.pc_inc, 1'b1);

        // Branch and sequential decode table
        foreach (tbl[i]) begin
            apply(tbl[i].op, tbl[i].c, tbl[i].z, 0);
            apply(tbl[i].op, tbl[i].c, tbl[i].z, 0);
            check1($sformatf("tbl%0d_ld", i), bus.pc_ld, tbl[i].ld);
            check1($sformatf("tbl%0d_inc", i), bus.pc_inc, tbl[i].inc);
            check1($sformatf("tbl%0d_sel", i), bus.pc_mux_sel == 2'b00, 1'b1);
        end

        // CALL then RET
        apply(5'd9, 0, 0, 0);
        apply(5'd9, 0, 0, 0);
        check1("call_push", bus.stk_push, 1'b1);
        check1("call_sel00", bus.pc_mux_sel == 2'b00, 1'b1);
        apply(5'd10, 0, 0, 0);
        check1("call_depth1", bus.stk_depth == 6'd1, 1'b1);
        apply(5'd10, 0, 0, 0);
        check1("ret_pop", bus.stk_pop, 1'b1);
        check1("ret_sel01", bus.pc_mux_sel == 2'b01, 1'b1);
        apply(5'd0, 0, 0, 0);
        check1("ret_depth0", bus.stk_depth == 6'd0, 1'b1);
        apply(5'd0, 0, 0, 0);

        // SEI, INT pulse during a sequential instruction, then RETIE
        instr(5'd12, 0, 0, 0);
        instr(5'd0, 0, 0, 1);
        apply(5'd0, 0, 0, 0);
        check1("intr_push", bus.stk_push, 1'b1);
        check1("intr_sel10", bus.pc_mux_sel == 2'b10, 1'b1);
        check1("intr_ack", bus.int_ack, 1'b1);
        apply(5'd11, 0, 0, 0);
        check1("intr_ie_clr", bus.ie, 1'b0);
        apply(5'd11, 0, 0, 0);
        check1("retie_pop", bus.stk_pop, 1'b1);
        apply(5'd0, 0, 0, 0);
        check1("retie_ie_set", bus.ie, 1'b1);
        apply(5'd0, 0, 0, 0);

        // INT edge coinciding with SEI is taken right after that EXEC
        instr(5'd13, 0, 0, 0);
        instr(5'd12, 0, 0, 1);
        apply(5'd0, 0, 0, 0);
        check1("sei_int_ack", bus.int_ack, 1'b1);
        instr(5'd11, 0, 0, 0);

        // Full stack: interrupt deferred, taken after a RET, then overflow
        do_reset();
        instr(5'd12, 0, 0, 0);
        for (int i = 0; i < int'(StkMax); i++) instr(5'd9, 0, 0, 0);
        instr(5'd0, 0, 0, 1);
        check1("full_depth", bus.stk_depth == 6'(StkMax), 1'b1);
        apply(5'd10, 0, 0, 0);
        check1("deferred_no_ack", bus.int_ack, 1'b0);
        apply(5'd10, 0, 0, 0);
        apply(5'd9, 0, 0, 0);
        check1("deferred_taken", bus.int_ack, 1'b1);
        apply(5'd9, 0, 0, 0);
        apply(5'd9, 0, 0, 0);
        check1("ovf_no_push", bus.stk_push, 1'b0);
        check1("ovf_no_ld", bus.pc_ld, 1'b0);
        apply(5'd0, 0, 0, 0);
        check1("ovf_err", bus.stk_err, 1'b1);
        for (int i = 0; i < 4; i++) apply(5'd9, 1, 1, i[0]);
        check1("halt_err_held", bus.stk_err, 1'b1);

        // Underflow
        do_reset();
        apply(5'd10, 0, 0, 0);
        apply(5'd10, 0, 0, 0);
        check1("udf_no_pop", bus.stk_pop, 1'b0);
        apply(5'd0, 0, 0, 0);
        check1("udf_err", bus.stk_err, 1'b1);

        // Reset asserted during EXEC of a CALL
        do_reset();
        apply(5'd9, 0, 0, 0);
        apply(5'd9, 0, 0, 0);
        check1("pre_rst_push", bus.stk_push, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check16("mid_rst_zero", got_vec(), 16'h0000);
        apply(5'd9, 0, 0, 0, 1'b0);
        apply(5'd9, 0, 0, 0, 1'b1);
        apply(5'd9, 0, 0, 0);
        check1("restart_init", bus.pc_ld && bus.pc_mux_sel == 2'b11, 1'b1);

        // Randomized instruction streams
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int k = 0; k < 150; k++) begin
                rop = 5'($urandom_range(0, 15));
                if (rop == 5'd14 || rop == 5'd15) rop = 5'($urandom);
                if ((rop == 5'd10 || rop == 5'd11) && $urandom_range(0, 2) != 0) rop = 5'd9;
                apply(rop, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
